// File: rtl/im_pipe.sv
// Instruction memory for the fetch stage: registered read with 1 or 2 cycles of latency,
// fetch stall, byte-strobed program-load port and a post-reset zero-clear sequencer.
module im_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IM_read,
    input  logic [ADDR_W-1:0]   IM_addr,
    input  logic                IM_stall,
    input  logic                IM_write,
    input  logic [ADDR_W-1:0]   IM_waddr,
    input  logic [DATA_W-1:0]   IM_wdata,
    input  logic [DATA_W/8-1:0] IM_wstrb,
    output logic [DATA_W-1:0]   IM_out,
    output logic                IM_valid,
    output logic                IM_err,
    output logic                IM_busy
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB       = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               busy;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               rd_in_range, wr_in_range, accept;
    logic [IDX_W-1:0]   rd_idx, wr_idx;
    logic [DATA_W-1:0]  rd_data;

    logic               s1_valid_q, s1_err_q;
    logic [DATA_W-1:0]  s1_data_q;

    assign busy    = (state_q == StClear);
    assign IM_busy = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= (INIT_ZERO != 0) ? StClear : StIdle;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end
            end
            StIdle: ;
            default: state_d = StIdle;
        endcase
    end

    assign rd_in_range = ({1'b0, IM_addr} < DEPTH_L);
    assign wr_in_range = ({1'b0, IM_waddr} < DEPTH_L);
    assign rd_idx      = IM_addr[IDX_W-1:0];
    assign wr_idx      = IM_waddr[IDX_W-1:0];
    assign accept      = IM_read && !busy && !IM_stall;
    assign rd_data     = rd_in_range ? mem_q[rd_idx] : '0;

    // No reset on the array: only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (IM_write && wr_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (IM_wstrb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= IM_wdata[8*b +: 8];
                end
            end
        end
    end

    // Array read happens at the accept edge, so a same-cycle write is seen only by later fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
        end else if (!IM_stall) begin
            s1_valid_q <= accept;
            s1_err_q   <= accept && !rd_in_range;
            if (accept) begin
                s1_data_q <= rd_data;
            end
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic              out_valid_q, out_err_q;
        logic [DATA_W-1:0] out_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_err_q   <= 1'b0;
                out_data_q  <= '0;
            end else if (!IM_stall) begin
                out_valid_q <= s1_valid_q;
                out_err_q   <= s1_err_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_data_q;
                end
            end
        end

        assign IM_out   = out_data_q;
        assign IM_valid = out_valid_q;
        assign IM_err   = out_err_q;
    end else begin : g_lat1
        assign IM_out   = s1_data_q;
        assign IM_valid = s1_valid_q;
        assign IM_err   = s1_err_q;
    end

endmodule

// File: tb/tb_im_pipe.sv
// Bench for im_pipe: one LATENCY=1 and one LATENCY=2 instance share stimulus; a scoreboard
// fed by an array/queue reference model checks every valid pulse.
module tb_im_pipe;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          IM_read = 1'b0, IM_stall = 1'b0, IM_write = 1'b0;
    logic [AW-1:0] IM_addr = '0, IM_waddr = '0;
    logic [DW-1:0] IM_wdata = '0;
    logic [3:0]    IM_wstrb = '0;

    logic [DW-1:0] out1, out2;
    logic          valid1, valid2, err1, err2, busy1, busy2;

    always #5 clk = ~clk;

    im_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(1), .INIT_ZERO(1)) u_dut1 (
        .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .IM_stall(IM_stall),
        .IM_write(IM_write), .IM_waddr(IM_waddr), .IM_wdata(IM_wdata), .IM_wstrb(IM_wstrb),
        .IM_out(out1), .IM_valid(valid1), .IM_err(err1), .IM_busy(busy1)
    );

    im_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(2), .INIT_ZERO(1)) u_dut2 (
        .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .IM_stall(IM_stall),
        .IM_write(IM_write), .IM_waddr(IM_waddr), .IM_wdata(IM_wdata), .IM_wstrb(IM_wstrb),
        .IM_out(out2), .IM_valid(valid2), .IM_err(err2), .IM_busy(busy2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, remaining busy cycles, expected-response queues.
    logic [31:0] ref_mem [];
    int          busy_left = DEPTH;
    bit          last_acc  = 1'b0;
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];

    task automatic model_reset();
        busy_left = DEPTH;
        last_acc  = 1'b0;
        q1.delete();
        q2.delete();
        foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    endtask

    task automatic model_step();
        int          a;
        int          w;
        logic [32:0] e;
        logic [31:0] word;
        if (rst) begin
            model_reset();
            return;
        end
        a = int'(IM_addr);
        w = int'(IM_waddr);
        last_acc = IM_read && (busy_left == 0) && !IM_stall;
        if (last_acc) begin
            e = (a < DEPTH) ? {1'b0, ref_mem[a]} : {1'b1, 32'h0};
            q1.push_back(e);
            q2.push_back(e);
        end
        if (IM_write && (busy_left == 0) && (w < DEPTH)) begin
            word = ref_mem[w];
            for (int b = 0; b < 4; b++) begin
                if (IM_wstrb[b]) word[8*b +: 8] = IM_wdata[8*b +: 8];
            end
            ref_mem[w] = word;
        end
        if (busy_left > 0) busy_left--;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor
    logic [DW-1:0] p_out1 = '0, p_out2 = '0;
    logic          p_v1 = 1'b0, p_v2 = 1'b0, p_e1 = 1'b0, p_e2 = 1'b0;
    bit            p_stall = 1'b0;

    task automatic mon_dut(input int id, input logic [31:0] o, input logic v, input logic e,
                           input logic [31:0] po, input logic pv, input logic pe);
        logic [32:0] x;
        bit          empty;
        if (!v) chk($sformatf("L%0d err_without_valid", id), e, 1'b0);
        if (p_stall) chk($sformatf("L%0d stall_freeze", id), {o, v, e}, {po, pv, pe});
        if (v && !IM_stall) begin
            empty = (id == 1) ? (q1.size() == 0) : (q2.size() == 0);
            if (empty) begin
                chk($sformatf("L%0d unexpected_valid", id), v, 1'b0);
            end else begin
                x = (id == 1) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("L%0d data", id), o, x[31:0]);
                chk($sformatf("L%0d err", id), e, x[32]);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("busy1", busy1, busy_left > 0);
        chk("busy2", busy2, busy_left > 0);
        if (!rst) begin
            mon_dut(1, out1, valid1, err1, p_out1, p_v1, p_e1);
            mon_dut(2, out2, valid2, err2, p_out2, p_v2, p_e2);
        end
        p_out1  = out1;  p_v1 = valid1;  p_e1 = err1;
        p_out2  = out2;  p_v2 = valid2;  p_e2 = err2;
        p_stall = rst ? 1'b0 : IM_stall;
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        int k = 0;
        IM_read = 1'b1;
        IM_addr = AW'(a);
        do begin
            tick();
            k++;
        end while (!last_acc && k < 60);
        if (!last_acc) chk("read_accept_timeout", 1'b0, 1'b1);
        IM_read = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        IM_write = 1'b1;
        IM_waddr = AW'(a);
        IM_wdata = d;
        IM_wstrb = s;
        tick();
        IM_write = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q1.size() + q2.size()) != 0 && k < 30) begin
            tick();
            k++;
        end
        chk("drain_pending", q1.size() + q2.size(), 0);
    endtask

    task automatic pulse_rst(input int cycles);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst out1", out1, 0);
        chk("rst valid1", valid1, 0);
        chk("rst err1", err1, 0);
        chk("rst out2", out2, 0);
        chk("rst valid2", valid2, 0);
        chk("rst busy1", busy1, 1);
        chk("rst busy2", busy2, 1);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ref_mem = new[DEPTH];
        model_reset();
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("init out1", out1, 0);
        chk("init valid1", valid1, 0);
        chk("init err1", err1, 0);
        chk("init out2", out2, 0);
        chk("init valid2", valid2, 0);
        chk("init busy1", busy1, 1);
        @(negedge clk);
        #2 rst = 1'b0;

        // Clear sequence; a read held from the start waits out busy and returns zero
        rd(7);
        chk("clear rd7 data", out1, 32'h0);
        chk("clear rd7 valid", valid1, 1'b1);
        chk("clear rd7 err", err1, 1'b0);
        rd(12);
        drain();

        // Byte-strobed writes and latency
        wr(3, 32'hDEADBEEF, 4'b1111);
        wr(3, 32'h000000AA, 4'b0001);
        IM_read = 1'b1;
        IM_addr = AW'(3);
        tick();
        IM_read = 1'b0;
        chk("lat accepted", last_acc, 1'b1);
        chk("lat1 data", out1, 32'hDEADBEAA);
        chk("lat1 valid", valid1, 1'b1);
        chk("lat2 not yet", valid2, 1'b0);
        tick();
        chk("lat2 data", out2, 32'hDEADBEAA);
        chk("lat2 valid", valid2, 1'b1);
        drain();

        // Back-to-back reads with a stall after the first accept
        wr(1, 32'h11111111, 4'b1111);
        wr(2, 32'h22222222, 4'b1111);
        IM_read = 1'b1;
        IM_addr = AW'(1);
        tick();
        IM_stall = 1'b1;
        IM_addr  = AW'(2);
        tick();
        chk("stalled read dropped", last_acc, 1'b0);
        IM_stall = 1'b0;
        tick();
        IM_addr = AW'(3);
        tick();
        IM_read = 1'b0;
        drain();

        // Same-cycle write and read to one address
        IM_write = 1'b1;
        IM_waddr = AW'(5);
        IM_wdata = 32'h12345678;
        IM_wstrb = 4'b1111;
        IM_read  = 1'b1;
        IM_addr  = AW'(5);
        tick();
        IM_write = 1'b0;
        IM_read  = 1'b0;
        chk("rw same old", out1, 32'h0);
        rd(5);
        chk("rw next new", out1, 32'h12345678);
        drain();

        // Out-of-range read and write
        rd(20);
        chk("oor data", out1, 32'h0);
        chk("oor valid", valid1, 1'b1);
        chk("oor err", err1, 1'b1);
        wr(20, 32'hCAFEF00D, 4'b1111);
        for (int i = 0; i < DEPTH; i++) begin
            IM_read = 1'b1;
            IM_addr = AW'(i);
            tick();
        end
        IM_read = 1'b0;
        drain();
        rd(3);
        drain();

        // Reset from idle, then reset again in clear cycle 7; writes while busy are dropped
        pulse_rst(2);
        repeat (7) tick();
        pulse_rst(2);
        wr(2, 32'hFFFFFFFF, 4'b1111);
        rd(2);
        chk("busy write dropped", out1, 32'h0);
        drain();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            if (!(IM_read && !last_acc)) begin
                IM_read = ($urandom_range(0, 99) < 60);
                IM_addr = AW'($urandom_range(0, 19));
            end
            IM_write = ($urandom_range(0, 99) < 35);
            IM_waddr = AW'($urandom_range(0, 19));
            IM_wdata = $urandom;
            IM_wstrb = 4'($urandom_range(0, 15));
            IM_stall = ($urandom_range(0, 99) < 20);
            tick();
        end
        IM_read  = 1'b0;
        IM_write = 1'b0;
        IM_stall = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/im_pipe.md
Name: im_pipe

Overview:
Parametrised instruction memory for the pipeline fetch stage.
- Generalises the fixed-size combinational IM into a configurable-width, configurable-depth, registered-read macro.
- Adds selectable read latency (1 or 2), a fetch stall/hold input, and a byte-strobed program-load write port.
- Adds a post-reset zero-clear sequencer and out-of-range address detection.

Parameters:
DATA_W, 32, instruction word width in bits; multiple of 8.
ADDR_W, 10, word-address width.
DEPTH, 1024, number of words; 2 <= DEPTH <= 2**ADDR_W.
LATENCY, 1, read latency in cycles; legal values 1 or 2.
INIT_ZERO, 1, 1 = run clear sequencer after reset; 0 = contents undefined after reset, no clear.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-high.
IM_read  in  1  fetch request.
IM_addr  in  ADDR_W  fetch word address.
IM_stall  in  1  hold the read pipeline and outputs.
IM_write  in  1  program-load write enable.
IM_waddr  in  ADDR_W  write word address.
IM_wdata  in  DATA_W  write data.
IM_wstrb  in  DATA_W/8  byte enables; bit k covers bits 8k+7:8k.
IM_out  out  DATA_W  fetched instruction (registered).
IM_valid  out  1  IM_out holds fresh data this cycle.
IM_err  out  1  qualifies IM_valid; fetch address was >= DEPTH.
IM_busy  out  1  clear sequencer running; reads and writes are not accepted.

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-high.
- Reset values:
  - IM_out = 0, IM_valid = 0, IM_err = 0.
  - All pipeline valid bits = 0.
  - IM_busy = INIT_ZERO.
  - Clear counter = 0.
  - FSM = CLEAR if INIT_ZERO, else IDLE.
- FSM states: CLEAR, IDLE.
  - CLEAR: one word per cycle, write 0 to address clr_cnt, then clr_cnt++.
  - CLEAR -> IDLE on the cycle that writes DEPTH-1.
  - IM_busy deasserts the first cycle in IDLE. Clear therefore takes exactly DEPTH cycles after rst falls.
  - rst asserted mid-clear: counter returns to 0 and the clear restarts from address 0.
- Read accept: read is accepted in cycle t when IM_read=1, IM_busy=0 and IM_stall=0.
  - Requests while busy or stalled are dropped. The requester holds IM_read/IM_addr until a cycle where it is accepted.
- Read latency:
  - LATENCY=1: IM_out and IM_valid update at the edge ending cycle t; visible in cycle t+1.
  - LATENCY=2: one extra registered stage; visible in cycle t+2.
  - Back-to-back accepts give one result per cycle.
- Valid pulse: IM_valid is high for exactly one unstalled cycle per accepted read, otherwise 0.
  - IM_out holds its last value when IM_valid = 0; it is not zeroed.
- Stall: while IM_stall = 1, all pipeline registers, IM_out, IM_valid and IM_err freeze. Nothing is lost and nothing is duplicated.
- Out-of-range read: IM_addr >= DEPTH returns IM_out = 0 and IM_err = 1 alongside IM_valid. IM_err = 0 whenever IM_valid = 0.
- Write:
  - Performed at the rising edge when IM_write = 1, IM_busy = 0 and IM_waddr < DEPTH.
  - Only bytes with strobe set are updated.
  - Independent of IM_stall.
  - Writes during CLEAR and out-of-range writes are silently dropped.
- Same-cycle read and write to the same address: read-first. The fetch returns pre-write data; the next fetch sees the new data.
- Memory array is not otherwise touched by rst. Only the sequencer zeroes it.

Test Plan:
1. DEPTH=16, INIT_ZERO=1: release rst at cycle 0 -> IM_busy=1 for cycles 0..15, 0 at cycle 16. Any read accepted afterwards returns 0x00000000 with IM_valid=1 and IM_err=0.
2. LATENCY=1: write 0xDEADBEEF to addr 3 with wstrb=4'b1111, then write 0x000000AA to addr 3 with wstrb=4'b0001. Read addr 3 at cycle t -> IM_out=0xDEADBEAA and IM_valid=1 at t+1. Repeat with LATENCY=2 -> same data at t+2.
3. Back-to-back reads of addrs 1,2,3 with IM_stall=1 in the cycle after the first accept -> three valid pulses in order: data of 1, 2, 3. Outputs are frozen during the stall cycle; no duplicate or missing pulse.
4. Same-cycle write of 0x12345678 and read, both to addr 5 (old value 0x0) -> that read returns 0x0. The next read of addr 5 returns 0x12345678.
5. DEPTH=16: read addr 20 -> IM_valid=1, IM_err=1, IM_out=0. Write to addr 20 -> no array word changes; a full readback of 0..15 is unchanged.
6. Assert rst at clear cycle 7 for 2 cycles -> outputs are immediately at reset values and busy stays 1. After release, busy lasts exactly 16 more cycles. A write issued during busy is dropped; confirmed by readback returning 0.
